// File: rtl/mul_sched_pkg.sv
// Shared definitions for the round-robin multiplier scheduler.
//   OPERAND_W / PRODUCT_W : operand and product widths of the shared multiplier
//   ID_MAX_W              : widest requester ID (N_REQ up to 8)
//   id_w()                : requester ID width for a given requester count
//   pipe_in_t             : payload entering the multiplier pipe {valid, id, a, b}
package mul_sched_pkg;

  localparam int unsigned OPERAND_W = 4;
  localparam int unsigned PRODUCT_W = 8;
  localparam int unsigned ID_MAX_W  = 3;

  function automatic int unsigned id_w(input int unsigned n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [ID_MAX_W-1:0]  id;
    logic [OPERAND_W-1:0] a;
    logic [OPERAND_W-1:0] b;
  } pipe_in_t;

endpackage

// File: rtl/mul_pipe.sv
// LATENCY-stage registered 4x4 unsigned multiplier.
//   clk, rst       : clock, async active-high reset (clears valid bits only)
//   in_pay         : {valid, id, a, b} issued by the scheduler
//   out_valid      : product valid after LATENCY edges
//   out_id         : requester ID travelling alongside the product
//   out_prod       : zero-extended a*b
module mul_pipe
  import mul_sched_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  pipe_in_t             in_pay,
  output logic                 out_valid,
  output logic [ID_MAX_W-1:0]  out_id,
  output logic [PRODUCT_W-1:0] out_prod
);

  logic [LATENCY-1:0]   vld_q, vld_d;
  logic [ID_MAX_W-1:0]  id_q   [LATENCY];
  logic [ID_MAX_W-1:0]  id_d   [LATENCY];
  logic [PRODUCT_W-1:0] prod_q [LATENCY];
  logic [PRODUCT_W-1:0] prod_d [LATENCY];

  // The product is formed ahead of the first register; later stages only delay it.
  always_comb begin
    vld_d     = '0;
    vld_d[0]  = in_pay.valid;
    id_d[0]   = in_pay.id;
    prod_d[0] = PRODUCT_W'(in_pay.a) * PRODUCT_W'(in_pay.b);
    for (int unsigned s = 1; s < LATENCY; s++) begin
      vld_d[s]  = vld_q[s-1];
      id_d[s]   = id_q[s-1];
      prod_d[s] = prod_q[s-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Data stages are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < LATENCY; s++) begin
      id_q[s]   <= id_d[s];
      prod_q[s] <= prod_d[s];
    end
  end

  assign out_valid = vld_q[LATENCY-1];
  assign out_id    = id_q[LATENCY-1];
  assign out_prod  = prod_q[LATENCY-1];

endmodule

// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one pipelined 4x4 multiplier among N_REQ
// requesters, with a credit-protected in-order result FIFO.
//   clk, rst            : clock, async active-high reset
//   req_valid/req_ready : per-requester handshake (at most one ready high)
//   req_a, req_b        : packed 4-bit operands, requester i at [4i+3:4i]
//   resp_valid/ready    : result FIFO head handshake (first-word fall-through)
//   resp_data, resp_id  : product and issuing requester at the FIFO head
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned DEPTH   = LATENCY + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [4*N_REQ-1:0]       req_a,
  input  logic [4*N_REQ-1:0]       req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [7:0]               resp_data,
  output logic [$clog2(N_REQ)-1:0] resp_id
);

  localparam int unsigned ID_W = id_w(N_REQ);
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW   = $clog2(DEPTH + 1);

  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]        credits_q, credits_d;
  logic [CW-1:0]        count_q, count_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PRODUCT_W-1:0] mem_data_q [DEPTH];
  logic [PRODUCT_W-1:0] mem_data_d [DEPTH];
  logic [ID_W-1:0]      mem_id_q   [DEPTH];
  logic [ID_W-1:0]      mem_id_d   [DEPTH];

  logic [N_REQ-1:0]     grant;
  logic [ID_W-1:0]      grant_id;
  logic                 accept;
  logic                 pop;
  int unsigned          arb_idx;
  int unsigned          op_base;
  pipe_in_t             pipe_in;

  logic                 pipe_valid;
  logic [ID_MAX_W-1:0]  pipe_id;
  logic [PRODUCT_W-1:0] pipe_prod;
  logic                 unused_pipe_id;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  // Scan starts at ptr and wraps; only registered credits gate the grant, so
  // a pop in the same cycle never reaches req_ready combinationally.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    arb_idx  = 0;
    if (!rst && credits_q != '0) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        arb_idx = (32'(ptr_q) + k) % N_REQ;
        if (grant == '0 && req_valid[arb_idx]) begin
          grant[arb_idx] = 1'b1;
          grant_id       = ID_W'(arb_idx);
        end
      end
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign pop       = resp_valid & resp_ready;

  always_comb begin
    op_base       = 32'(grant_id) * OPERAND_W;
    pipe_in.valid = accept;
    pipe_in.id    = ID_MAX_W'(grant_id);
    pipe_in.a     = req_a[op_base +: OPERAND_W];
    pipe_in.b     = req_b[op_base +: OPERAND_W];
  end

  mul_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_pay    (pipe_in),
    .out_valid (pipe_valid),
    .out_id    (pipe_id),
    .out_prod  (pipe_prod)
  );

  // IDs above ID_W are always zero-extended; fold them so nothing dangles.
  assign unused_pipe_id = ^(pipe_id >> ID_W);

  always_comb begin
    ptr_d     = ptr_q;
    credits_d = credits_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_data_d = mem_data_q;
    mem_id_d   = mem_id_q;

    if (accept) begin
      ptr_d = (32'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
    end

    case ({accept, pop})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase

    if (pipe_valid) begin
      mem_data_d[wr_ptr_q] = pipe_prod;
      mem_id_d[wr_ptr_q]   = pipe_id[ID_W-1:0];
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({pipe_valid, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q     <= '0;
      credits_q <= CW'(DEPTH);
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        mem_data_q[e] <= '0;
        mem_id_q[e]   <= '0;
      end
    end else begin
      ptr_q      <= ptr_d;
      credits_q  <= credits_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_data_q <= mem_data_d;
      mem_id_q   <= mem_id_d;
    end
  end

  assign resp_valid = (count_q != '0);
  assign resp_data  = mem_data_q[rd_ptr_q];
  assign resp_id    = mem_id_q[rd_ptr_q];

  // Credits bound in-flight plus stored results to DEPTH, so a write into a
  // full FIFO means the credit accounting is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(pipe_valid && (32'(count_q) == DEPTH)));

endmodule

// File: tb/tb_mul_sched.sv
module tb_mul_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int id;
    int a;
    int b;
    int prod;
  } vec_t;

  vec_t vecs[7];

  mul_sched #(
    .N_REQ   (4),
    .LATENCY (3),
    .DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
  endtask

  task automatic do_reset();
    req_valid  = '0;
    resp_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Pops with resp_ready high for a bounded number of cycles and compares
  // every response against the expected in-order list.
  task automatic drain(input string tag, input int n_exp, input int ids[8], input int prods[8]);
    int n;
    n = 0;
    resp_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (resp_valid) begin
        if (n < n_exp && n < 8) begin
          chk($sformatf("%s_id%0d", tag, n), 32'(resp_id), 32'(ids[n]));
          chk($sformatf("%s_data%0d", tag, n), 32'(resp_data), 32'(prods[n]));
        end
        n++;
      end
      tick();
    end
    resp_ready = 1'b0;
    chk($sformatf("%s_count", tag), 32'(n), 32'(n_exp));
  endtask

  initial begin
    int exp_rdy[7];
    int exp_id[6];
    int exp_pr[6];
    int ids[8];
    int prods[8];
    int n;

    vecs[0] = '{0, 3, 5, 15};
    vecs[1] = '{1, 15, 15, 225};
    vecs[2] = '{2, 0, 9, 0};
    vecs[3] = '{3, 1, 15, 15};
    vecs[4] = '{0, 15, 1, 15};
    vecs[5] = '{2, 7, 6, 42};
    vecs[6] = '{1, 12, 11, 132};

    // Reset state: ready must stay low while rst is high even with all valid.
    rst = 1'b1;
    req_valid = 4'hF;
    req_a = 16'h3333;
    req_b = 16'h5555;
    tick();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    do_reset();

    // Single-requester vectors: grant, 3-cycle latency, product, id, pop.
    for (int v = 0; v < 7; v++) begin
      req_valid = 4'(1 << vecs[v].id);
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
      #1;
      chk($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(1 << vecs[v].id));
      tick();
      req_valid = '0;
      #1;
      chk($sformatf("vec%0d_early0", v), 32'(resp_valid), 32'd0);
      tick();
      tick();
      chk($sformatf("vec%0d_early2", v), 32'(resp_valid), 32'd0);
      tick();
      chk($sformatf("vec%0d_valid", v), 32'(resp_valid), 32'd1);
      chk($sformatf("vec%0d_data", v), 32'(resp_data), 32'(vecs[v].prod));
      chk($sformatf("vec%0d_id", v), 32'(resp_id), 32'(vecs[v].id));
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      #1;
      chk($sformatf("vec%0d_popped", v), 32'(resp_valid), 32'd0);
    end

    // Full contention: four credits run out after four accepts, the freed
    // credit from the first pop is usable one cycle later.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, i + 1, i + 2);
    exp_rdy = '{1, 2, 4, 8, 0, 1, 2};
    exp_id  = '{0, 1, 2, 3, 0, 1};
    exp_pr  = '{2, 6, 12, 20, 2, 6};
    resp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 24; c++) begin
      req_valid = (c < 7) ? 4'hF : 4'h0;
      #1;
      if (c < 7) chk($sformatf("cont_rdy%0d", c), 32'(req_ready), 32'(exp_rdy[c]));
      if (resp_valid) begin
        if (n < 6) begin
          chk($sformatf("cont_id%0d", n), 32'(resp_id), 32'(exp_id[n]));
          chk($sformatf("cont_data%0d", n), 32'(resp_data), 32'(exp_pr[n]));
        end
        n++;
      end
      tick();
    end
    resp_ready = 1'b0;
    chk("cont_count", 32'(n), 32'd6);

    // Backpressure: exactly four accepts, then a single pop admits one more.
    do_reset();
    req_valid = 4'b0100;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) set_ops(2, c + 1, 3);
      #1;
      chk($sformatf("bp_rdy%0d", c), 32'(req_ready), (c < 4) ? 32'd4 : 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp_rdy_pop_cycle", 32'(req_ready), 32'd0);
    chk("bp_head_valid", 32'(resp_valid), 32'd1);
    chk("bp_head_data", 32'(resp_data), 32'd3);
    chk("bp_head_id", 32'(resp_id), 32'd2);
    tick();
    resp_ready = 1'b0;
    set_ops(2, 5, 3);
    #1;
    chk("bp_rdy_after_pop", 32'(req_ready), 32'd4);
    chk("bp_head2_data", 32'(resp_data), 32'd6);
    tick();
    chk("bp_rdy_refull", 32'(req_ready), 32'd0);
    req_valid = '0;
    ids   = '{2, 2, 2, 2, 0, 0, 0, 0};
    prods = '{6, 9, 12, 15, 0, 0, 0, 0};
    drain("bp", 4, ids, prods);

    // Reset mid-flight: head visible, two products still in the pipe.
    do_reset();
    req_valid = 4'b0001; set_ops(0, 2, 2); tick();
    req_valid = 4'b0010; set_ops(1, 3, 3); tick();
    req_valid = 4'b0100; set_ops(2, 4, 4); tick();
    req_valid = '0;
    tick();
    chk("mid_head_valid", 32'(resp_valid), 32'd1);
    chk("mid_head_data", 32'(resp_data), 32'd4);
    rst = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_data", 32'(resp_data), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'd1);
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk($sformatf("mid_stale%0d", c), 32'(resp_valid), 32'd0);
    end
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("mid_credit%0d", c), 32'(req_ready), (c < 4) ? 32'd4 : 32'd0);
      tick();
    end
    req_valid = '0;
    do_reset();

    // Pointer wrap: after accepts from req3 the next scan starts at req0.
    resp_ready = 1'b1;
    req_valid = 4'b1000;
    set_ops(3, 2, 5);
    set_ops(0, 1, 1);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) req_valid = 4'hF;
      #1;
      chk($sformatf("wrap_rdy%0d", c), 32'(req_ready), (c < 3) ? 32'd8 : 32'd1);
      tick();
    end
    req_valid = '0;
    ids   = '{3, 3, 3, 0, 0, 0, 0, 0};
    prods = '{10, 10, 10, 1, 0, 0, 0, 0};
    drain("wrap", 4, ids, prods);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
